// File: rtl/sipo16_pkg.sv
// Shared definitions for the serial-in / parallel-out deserializer.
//   DESER_WIDTH   : default deserialized word width
//   deser_state_t : frame FSM states (IDLE waiting for start, SHIFT collecting bits)
package sipo16_pkg;

  localparam int DESER_WIDTH = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } deser_state_t;

endpackage

// File: rtl/deser_bit_cnt.sv
// Bit counter for the deserializer frame.
//   clk   in  rising-edge clock
//   rst   in  synchronous active-high reset (count -> 0)
//   clr   in  clear the count (new or aborted frame)
//   en    in  count one received bit
//   tc    out terminal count: the next enabled bit is the last bit of the word
// The count runs 0..WIDTH-1. Counting past the terminal value returns the
// counter to 0 explicitly, since that bit completes the word.
module deser_bit_cnt #(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(WIDTH - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr || (en && tc)) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tc = (count_reg == TERMINAL);

endmodule

// File: rtl/sipo16_deser.sv
// Serial-in / parallel-out deserializer with a one-word output register.
//   clk        in  rising-edge clock
//   rst        in  synchronous active-high reset
//   start      in  begin (or restart) a frame, one-cycle pulse
//   bit_valid  in  bit_in is valid this cycle
//   bit_in     in  serial data bit
//   out_ready  in  consumer accepts out_data
//   out_data   out assembled word (registered)
//   out_valid  out out_data holds an unconsumed word
//   busy       out a frame is being shifted
//   overrun    out sticky: a completed word was dropped because the output was full
// MSB_FIRST=1 places the first received bit in bit WIDTH-1, otherwise in bit 0.
module sipo16_deser
  import sipo16_pkg::*;
#(
  parameter int WIDTH     = DESER_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
);

  deser_state_t state_reg, state_next;

  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] out_data_reg;
  logic             out_valid_reg;
  logic             overrun_reg;

  logic bit_en;
  logic cnt_clr;
  logic word_done;
  logic tc;

  // Shift register contents after accepting bit_in this cycle.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (MSB_FIRST) begin : g_msb
        if (gi == 0) begin : g_in
          assign shifted[gi] = bit_in;
        end else begin : g_mv
          assign shifted[gi] = shift_reg[gi-1];
        end
      end else begin : g_lsb
        if (gi == WIDTH - 1) begin : g_in
          assign shifted[gi] = bit_in;
        end else begin : g_mv
          assign shifted[gi] = shift_reg[gi+1];
        end
      end
    end
  endgenerate

  deser_bit_cnt #(
    .WIDTH(WIDTH)
  ) u_bit_cnt (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .en (bit_en),
    .tc (tc)
  );

  // Frame control. start wins over bit_valid in every state, so a bit
  // presented alongside start is never captured.
  always_comb begin
    state_next = state_reg;
    bit_en     = 1'b0;
    cnt_clr    = 1'b0;
    word_done  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
          cnt_clr    = 1'b1;
        end
      end
      SHIFT: begin
        if (start) begin
          cnt_clr = 1'b1;
        end else if (bit_valid) begin
          bit_en = 1'b1;
          if (tc) begin
            word_done  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    shift_next = shift_reg;
    if (cnt_clr) begin
      shift_next = '0;
    end else if (bit_en) begin
      shift_next = shifted;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
    end
  end

  // Output stage. A completed word loads only if the register is empty or
  // being drained this same cycle; otherwise it is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (word_done && (!out_valid_reg || out_ready)) begin
        out_data_reg  <= shifted;
        out_valid_reg <= 1'b1;
      end else if (word_done) begin
        overrun_reg <= 1'b1;
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign overrun   = overrun_reg;
  assign busy      = (state_reg == SHIFT);

endmodule

// File: tb/tb_sipo16_deser.sv
// Directed self-checking bench for sipo16_deser. Two instances share the
// stimulus: dut_msb (MSB_FIRST=1) and dut_lsb (MSB_FIRST=0). Inputs change
// on the falling edge and outputs are checked on the falling edge.
module tb_sipo16_deser;

  logic clk = 1'b0;
  logic rst, start, bit_valid, bit_in, out_ready;

  logic [15:0] data_m, data_l;
  logic        valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sipo16_deser dut_msb (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid), .bit_in(bit_in),
    .out_ready(out_ready), .out_data(data_m), .out_valid(valid_m), .busy(busy_m),
    .overrun(ovr_m)
  );

  sipo16_deser #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid), .bit_in(bit_in),
    .out_ready(out_ready), .out_data(data_l), .out_valid(valid_l), .busy(busy_l),
    .overrun(ovr_l)
  );

  task automatic drive(input logic s, input logic bv, input logic b);
    @(negedge clk);
    start     = s;
    bit_valid = bv;
    bit_in    = b;
  endtask

  // Send bits [from, to) of w, either MSB-first or LSB-first order,
  // optionally with an idle cycle after every bit.
  task automatic send_bits(input logic [15:0] w, input bit lsb_order,
                           input int from, input int to, input bit gaps);
    for (int i = from; i < to; i++) begin
      drive(1'b0, 1'b1, lsb_order ? w[i] : w[15-i]);
      if (gaps) drive(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    n_checks++; if (data_m !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h expected %h", data_m, 16'h0000); end
    n_checks++; if (valid_m !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_m); end
    n_checks++; if (busy_m !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_m); end
    n_checks++; if (ovr_m !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", ovr_m); end
    n_checks++; if (busy_l !== 1'b0) begin n_fail++; $display("FAIL reset_busy_lsb: got %b expected 0", busy_l); end
    $display("reset: data=%h valid=%b busy=%b overrun=%b", data_m, valid_m, busy_m, ovr_m);
  endtask

  task automatic test_msb_word();
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b1);                 // bit alongside start must be ignored
    send_bits(16'hAAAA, 1'b0, 0, 8, 1'b0);
    n_checks++; if (busy_m !== 1'b1) begin n_fail++; $display("FAIL msb_busy_mid: got %b expected 1", busy_m); end
    n_checks++; if (valid_m !== 1'b0) begin n_fail++; $display("FAIL msb_valid_mid: got %b expected 0", valid_m); end
    send_bits(16'hAAAA, 1'b0, 8, 16, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    n_checks++; if (data_m !== 16'hAAAA) begin n_fail++; $display("FAIL msb_data: got %h expected %h", data_m, 16'hAAAA); end
    n_checks++; if (valid_m !== 1'b1) begin n_fail++; $display("FAIL msb_valid: got %b expected 1", valid_m); end
    n_checks++; if (busy_m !== 1'b0) begin n_fail++; $display("FAIL msb_busy_after: got %b expected 0", busy_m); end
    n_checks++; if (data_l !== 16'h5555) begin n_fail++; $display("FAIL msb_order_on_lsb_dut: got %h expected %h", data_l, 16'h5555); end
    drive(1'b0, 1'b0, 1'b0);
    n_checks++; if (valid_m !== 1'b0) begin n_fail++; $display("FAIL msb_valid_one_cycle: got %b expected 0", valid_m); end
    $display("msb word: data=%h (lsb dut %h)", data_m, data_l);
  endtask

  task automatic test_lsb_gaps();
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    send_bits(16'h5555, 1'b1, 0, 9, 1'b1);
    n_checks++; if (busy_l !== 1'b1) begin n_fail++; $display("FAIL gaps_busy_hold: got %b expected 1", busy_l); end
    n_checks++; if (valid_l !== 1'b0) begin n_fail++; $display("FAIL gaps_valid_early: got %b expected 0", valid_l); end
    send_bits(16'h5555, 1'b1, 9, 16, 1'b1);
    n_checks++; if (data_l !== 16'h5555) begin n_fail++; $display("FAIL lsb_data: got %h expected %h", data_l, 16'h5555); end
    n_checks++; if (valid_l !== 1'b1) begin n_fail++; $display("FAIL lsb_valid: got %b expected 1", valid_l); end
    n_checks++; if (data_m !== 16'hAAAA) begin n_fail++; $display("FAIL lsb_order_on_msb_dut: got %h expected %h", data_m, 16'hAAAA); end
    $display("lsb word with gaps: data=%h (msb dut %h)", data_l, data_m);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    send_bits(16'hF0F0, 1'b0, 0, 16, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    n_checks++; if (data_m !== 16'hF0F0) begin n_fail++; $display("FAIL ovr_first_data: got %h expected %h", data_m, 16'hF0F0); end
    n_checks++; if (ovr_m !== 1'b0) begin n_fail++; $display("FAIL ovr_first_flag: got %b expected 0", ovr_m); end
    drive(1'b1, 1'b0, 1'b0);
    send_bits(16'h1234, 1'b0, 0, 16, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    n_checks++; if (data_m !== 16'hF0F0) begin n_fail++; $display("FAIL ovr_data_kept: got %h expected %h", data_m, 16'hF0F0); end
    n_checks++; if (valid_m !== 1'b1) begin n_fail++; $display("FAIL ovr_valid_kept: got %b expected 1", valid_m); end
    n_checks++; if (ovr_m !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b expected 1", ovr_m); end
    n_checks++; if (ovr_l !== 1'b1) begin n_fail++; $display("FAIL ovr_flag_lsb: got %b expected 1", ovr_l); end
    out_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    n_checks++; if (valid_m !== 1'b0) begin n_fail++; $display("FAIL ovr_drain: got %b expected 0", valid_m); end
    n_checks++; if (ovr_m !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b expected 1", ovr_m); end
    $display("overrun: data=%h overrun=%b", data_m, ovr_m);
  endtask

  task automatic test_abort_and_back_to_back();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    send_bits(16'hFFFF, 1'b0, 0, 7, 1'b0);
    drive(1'b1, 1'b1, 1'b1);                 // restart; same-cycle bit ignored
    send_bits(16'h0F0F, 1'b0, 0, 16, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    n_checks++; if (data_m !== 16'h0F0F) begin n_fail++; $display("FAIL abort_data: got %h expected %h", data_m, 16'h0F0F); end
    n_checks++; if (valid_m !== 1'b1) begin n_fail++; $display("FAIL abort_valid: got %b expected 1", valid_m); end
    $display("abort: data=%h", data_m);
    drive(1'b1, 1'b0, 1'b0);
    send_bits(16'h3C5A, 1'b0, 0, 15, 1'b0);
    drive(1'b0, 1'b1, 1'b0);                 // last bit of 0x3C5A is 0
    out_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    n_checks++; if (data_m !== 16'h3C5A) begin n_fail++; $display("FAIL b2b_data: got %h expected %h", data_m, 16'h3C5A); end
    n_checks++; if (valid_m !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b expected 1", valid_m); end
    n_checks++; if (ovr_m !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b expected 0", ovr_m); end
    drive(1'b0, 1'b0, 1'b0);
    n_checks++; if (valid_m !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b expected 0", valid_m); end
    $display("back-to-back handshake: data=%h overrun=%b", data_m, ovr_m);
  endtask

  task automatic test_reset_mid_frame();
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    send_bits(16'hFFFF, 1'b0, 0, 10, 1'b0);
    @(negedge clk);
    rst = 1'b1; start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    n_checks++; if (busy_m !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy_m); end
    n_checks++; if (data_m !== 16'h0000) begin n_fail++; $display("FAIL midrst_data: got %h expected %h", data_m, 16'h0000); end
    n_checks++; if (valid_m !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", valid_m); end
    n_checks++; if (ovr_m !== 1'b0) begin n_fail++; $display("FAIL midrst_overrun: got %b expected 0", ovr_m); end
    drive(1'b1, 1'b0, 1'b0);
    send_bits(16'hBEEF, 1'b0, 0, 16, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    n_checks++; if (data_m !== 16'hBEEF) begin n_fail++; $display("FAIL midrst_next_data: got %h expected %h", data_m, 16'hBEEF); end
    n_checks++; if (valid_m !== 1'b1) begin n_fail++; $display("FAIL midrst_next_valid: got %b expected 1", valid_m); end
    $display("reset mid-frame then word: data=%h", data_m);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; out_ready = 1'b0;
    test_reset();
    test_msb_word();
    test_lsb_gaps();
    test_overrun();
    test_abort_and_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo16_deser.md
SIPO16_DESER -- requirements
Module: sipo16_deser

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the deserialized word width.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = first received bit lands in bit WIDTH-1; 0 = first bit lands in bit 0.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-004 start  in  1  begins a new frame (one-cycle pulse).
REQ-005 bit_valid  in  1  bit_in is valid this cycle.
REQ-006 bit_in  in  1  serial data bit.
REQ-007 out_ready  in  1  consumer (16-bit register stage) accepts out_data.
REQ-008 out_data  out  WIDTH  assembled word, registered.
REQ-009 out_valid  out  1  out_data holds an unconsumed word.
REQ-010 busy  out  1  high while a frame is being shifted.
REQ-011 overrun  out  1  sticky flag: a completed word was dropped.

Function
REQ-012 FSM states SHALL be IDLE and SHIFT; reset state is IDLE.
REQ-013 IDLE: start=1 -> SHIFT, with bit counter and shift register cleared; bit_valid in IDLE SHALL be ignored, including in the same cycle as start.
REQ-014 SHIFT: each cycle with bit_valid=1 SHALL shift bit_in into the shift register per MSB_FIRST and increment the counter (0..WIDTH-1).
REQ-015 SHIFT: cycles with bit_valid=0 SHALL hold the shift register and counter unchanged (no timeout).
REQ-016 start=1 while in SHIFT SHALL abort the partial frame: counter and shift register cleared, stay in SHIFT, and the same-cycle bit_valid ignored.
REQ-017 On the cycle the WIDTH-th bit is sampled, the full word SHALL be loaded into out_data on that clock edge, with out_valid=1 from the next cycle; FSM -> IDLE.
REQ-018 Latency SHALL be 1 cycle from the last bit sample to out_valid=1.
REQ-019 out_valid SHALL stay high, and out_data SHALL stay stable, until a cycle with out_valid=1 and out_ready=1; out_valid clears next cycle unless a new word loads in that cycle.
REQ-020 If a word completes while out_valid=1 and out_ready=0, the new word SHALL be dropped, out_data SHALL keep the old word, and overrun SHALL be set.
REQ-021 If a word completes in the same cycle as an accepting handshake (out_valid=1, out_ready=1), the new word SHALL load, out_valid SHALL remain 1, and no overrun SHALL occur.
REQ-022 overrun SHALL clear only on rst.
REQ-023 busy SHALL equal (state==SHIFT).
REQ-024 Counter width SHALL be $clog2(WIDTH); it SHALL never wrap silently (terminal count is WIDTH-1).

Reset
REQ-025 On rst=1 at a clock edge the block SHALL go to: state IDLE, counter 0, shift register 0, out_data 0, out_valid 0, busy 0, overrun 0.
REQ-026 rst SHALL take priority over start, bit_valid and out_ready in the same cycle; a partial frame is discarded.

Structure
REQ-027 A shared package sipo16_pkg SHALL hold the FSM state typedef (IDLE, SHIFT) and the constant DESER_WIDTH=16.
REQ-028 The bit counter with terminal-count output SHALL be a sub-module deser_bit_cnt (inputs clr, en; output tc).
REQ-029 All outputs SHALL be registered; there SHALL be no combinational path from inputs to out_data/out_valid.

Verification
REQ-030 rst held 2 cycles, then released -> all outputs 0, busy=0.
REQ-031 start, then 16 bits of 0xAAAA MSB-first with out_ready=1 -> out_data=16'hAAAA, out_valid for exactly 1 cycle starting 1 cycle after the 16th bit; busy low after.
REQ-032 MSB_FIRST=0, bits of 0x5555 sent LSB-first with gaps (bit_valid toggling) -> out_data=16'h5555.
REQ-033 Word 0xF0F0 completes with out_ready=0, then a second frame 0x1234 completes -> out_data stays 16'hF0F0 and overrun=1; out_ready=1 then -> out_valid drops.
REQ-034 start, 7 bits, then start again plus 16 bits of 0x0F0F -> out_data=16'h0F0F (partial frame discarded); second word completing on the same cycle as a handshake -> out_valid stays 1, overrun=0.
REQ-035 rst asserted after 10 bits -> next cycle all outputs 0, state IDLE; a following full frame of 0xBEEF -> out_data=16'hBEEF.
